// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit BCD up/down counter stepped once per rising edge of tick_src.
// Define BCD_TICK_COUNTER_SAT_EN for saturating mode; the default build wraps.
module bcd_tick_digit (
    input  logic [3:0] d,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] nxt,
    output logic       cout
);
    always_comb begin
        nxt  = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == 4'd9) begin
                    nxt  = 4'd0;
                    cout = 1'b1;
                end else begin
                    nxt = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    nxt  = 4'd9;
                    cout = 1'b1;
                end else begin
                    nxt = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_tick_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clockin,
    input  logic                  reset,
    input  logic                  tick_src,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc
);
    logic                    tick_q;
    logic                    step;
    logic [DIGITS-1:0][3:0]  cnt_q;
    logic [DIGITS-1:0][3:0]  cnt_nxt;
    logic [DIGITS-1:0][3:0]  ld_san;
    logic [DIGITS:0]         carry;
    logic                    wrap;

    assign step     = tick_src & ~tick_q & en;
    assign carry[0] = 1'b1;
    // A carry/borrow out of the top digit means the count crossed its boundary.
    assign wrap     = carry[DIGITS];

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            bcd_tick_digit u_dig (
                .d    (cnt_q[i]),
                .cin  (carry[i]),
                .up   (up),
                .nxt  (cnt_nxt[i]),
                .cout (carry[i+1])
            );
            assign ld_san[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    endgenerate

    always_ff @(posedge clockin) begin
        if (reset) begin
            cnt_q  <= '0;
            tc     <= 1'b0;
            tick_q <= 1'b1;  // a tick_src already high at release is not an edge
        end else begin
            tick_q <= tick_src;
            tc     <= 1'b0;
            if (load) begin
                cnt_q <= ld_san;
            end else if (step) begin
`ifdef BCD_TICK_COUNTER_SAT_EN
                if (wrap) tc <= 1'b1;
                else      cnt_q <= cnt_nxt;
`else
                cnt_q <= cnt_nxt;
                tc    <= wrap;
`endif
            end
        end
    end

    assign count = cnt_q;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter: directed scenarios plus randomized traffic vs an integer model.
module tb_bcd_tick_counter;
    localparam int DIGITS = 4;
    localparam int W = 4*DIGITS;

    logic         clockin = 1'b0;
    logic         reset = 1'b1, tick_src = 1'b0, en = 1'b1, up = 1'b1, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc;

    int n_tests = 0, n_fail = 0;
    int m_val = 0, m_max = 1;
    bit m_tq = 1'b1, m_tc = 1'b0;

    bcd_tick_counter #(.DIGITS(DIGITS)) dut (
        .clockin(clockin), .reset(reset), .tick_src(tick_src), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(count), .tc(tc)
    );

    always #5 clockin = ~clockin;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(input logic [W-1:0] lv);
        int r = 0, p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            int d = int'(lv[4*k +: 4]);
            if (d > 9) d = 0;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    // Advance the model from the currently driven inputs, then clock the DUT.
    task automatic cyc();
        bit stp;
        if (reset) begin
            m_val = 0; m_tc = 0; m_tq = 1;
        end else begin
            stp  = tick_src && !m_tq && en;
            m_tq = tick_src;
            m_tc = 0;
            if (load) m_val = load_to_int(load_val);
            else if (stp) begin
                if (up && m_val == m_max) begin
`ifdef BCD_TICK_COUNTER_SAT_EN
                    m_tc = 1;
`else
                    m_val = 0; m_tc = 1;
`endif
                end else if (!up && m_val == 0) begin
`ifdef BCD_TICK_COUNTER_SAT_EN
                    m_tc = 1;
`else
                    m_val = m_max; m_tc = 1;
`endif
                end else m_val = up ? m_val + 1 : m_val - 1;
            end
        end
        @(posedge clockin);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1; load_val = v; cyc(); load = 0;
    endtask

    task automatic do_edge();
        tick_src = 0; cyc(); tick_src = 1; cyc();
    endtask

    task automatic test_reset();
        reset = 1; tick_src = 1; en = 1; up = 1;
        cyc(); cyc();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_tests++;
            if (count !== 16'h0000 || tc !== 1'b0) begin
                n_fail++; $display("FAIL reset_hold count=%h tc=%b want 0000/0", count, tc);
            end
        end
        do_edge();
        n_tests++;
        if (count !== 16'h0001) begin
            n_fail++; $display("FAIL reset_first_edge count=%h want 0001", count);
        end
    endtask

    task automatic test_up_carry();
        logic [W-1:0] exp_v [3] = '{16'h0999, 16'h1000, 16'h1001};
        up = 1; do_load(16'h0998);
        for (int k = 0; k < 3; k++) begin
            do_edge();
            n_tests++;
            if (count !== exp_v[k] || tc !== 1'b0) begin
                n_fail++; $display("FAIL up_carry%0d count=%h tc=%b want %h/0", k, count, tc, exp_v[k]);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [W-1:0] e;
`ifdef BCD_TICK_COUNTER_SAT_EN
        e = 16'h9999;
`else
        e = 16'h0000;
`endif
        up = 1; do_load(16'h9999); do_edge();
        n_tests++;
        if (count !== e || tc !== 1'b1) begin
            n_fail++; $display("FAIL wrap_up count=%h tc=%b want %h/1", count, tc, e);
        end
        cyc();
        n_tests++;
        if (count !== e || tc !== 1'b0) begin
            n_fail++; $display("FAIL wrap_up_tc_one count=%h tc=%b want %h/0", count, tc, e);
        end
    endtask

    task automatic test_wrap_down();
        logic [W-1:0] e;
`ifdef BCD_TICK_COUNTER_SAT_EN
        e = 16'h0000;
`else
        e = 16'h9999;
`endif
        up = 0; do_load(16'h0000); do_edge();
        n_tests++;
        if (count !== e || tc !== 1'b1) begin
            n_fail++; $display("FAIL wrap_down count=%h tc=%b want %h/1", count, tc, e);
        end
        do_load(16'h1000); do_edge();
        n_tests++;
        if (count !== 16'h0999 || tc !== 1'b0) begin
            n_fail++; $display("FAIL borrow count=%h tc=%b want 0999/0", count, tc);
        end
    endtask

    task automatic test_load_step();
        up = 1; tick_src = 0; cyc();
        tick_src = 1; do_load(16'h12F4);
        n_tests++;
        if (count !== 16'h1204 || tc !== 1'b0) begin
            n_fail++; $display("FAIL load_step count=%h tc=%b want 1204/0", count, tc);
        end
        cyc();
        n_tests++;
        if (count !== 16'h1204) begin
            n_fail++; $display("FAIL load_step_after count=%h want 1204", count);
        end
    endtask

    task automatic test_enable();
        up = 1; do_load(16'h0500);
        en = 0;
        for (int k = 0; k < 5; k++) do_edge();
        n_tests++;
        if (count !== 16'h0500) begin
            n_fail++; $display("FAIL en_low count=%h want 0500", count);
        end
        en = 1; cyc(); cyc();
        n_tests++;
        if (count !== 16'h0500) begin
            n_fail++; $display("FAIL en_rise_high count=%h want 0500", count);
        end
        do_edge();
        n_tests++;
        if (count !== 16'h0501) begin
            n_fail++; $display("FAIL en_next_edge count=%h want 0501", count);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] picks [4] = '{16'h9998, 16'h0001, 16'h9999, 16'h0000};
        for (int k = 0; k < 600; k++) begin
            tick_src = 1'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            up       = 1'($urandom);
            load     = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 3)] : W'($urandom);
            cyc();
            n_tests++;
            if (count !== to_bcd(m_val) || tc !== m_tc) begin
                n_fail++;
                $display("FAIL random%0d count=%h tc=%b want %h/%b", k, count, tc, to_bcd(m_val), m_tc);
            end
        end
        reset = 0; load = 0;
    endtask

    initial begin
        for (int k = 0; k < DIGITS; k++) m_max *= 10;
        m_max -= 1;
        test_reset();
        test_up_carry();
        test_wrap_up();
        test_wrap_down();
        test_load_step();
        test_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
